// File: rtl/exp4_unidade_controle.sv
// exp4_unidade_controle
// ---------------------------------------------------------------------------
// Moore control unit for the experiment-4 game round. It waits for a player
// move and registers the switches. It then compares them against the ROM word
// at the current address and advances the address. The round ends on a full
// set of hits, on the first miss, or when no move arrives for TIMEOUT_CICLOS
// cycles.
//
// Ports:
//   clock              system clock, rising edge
//   reset              asynchronous active-high reset, forces state inicial
//   iniciar            level input, starts or restarts a round
//   jogada             raw move button (level), edge-detected here
//   chavesIgualMemoria datapath compare result (switches == ROM word)
//   fimC               datapath counter carry (address == 15)
//   zeraC / contaC     clear / increment datapath address counter
//   zeraR / registraR  clear / load datapath switch register
//   pronto             round finished (any end state)
//   acertou / errou / timeout   which way the round ended
//   db_estado          current state code for the HEX debug display
// ---------------------------------------------------------------------------
module exp4_unidade_controle #(
  parameter int TIMEOUT_CICLOS = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       chavesIgualMemoria,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  // The counter only has to reach TIMEOUT_CICLOS-1, so ceil(log2) bits suffice.
  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CICLOS - 1);

  // State codes double as the debug display value.
  typedef enum logic [3:0] {
    S_INICIAL     = 4'b0000,
    S_PREPARACAO  = 4'b0001,
    S_ESPERA      = 4'b0010,
    S_REGISTRA    = 4'b0100,
    S_COMPARACAO  = 4'b0101,
    S_PROXIMO     = 4'b0110,
    S_FIM_ACERTO  = 4'b1010,
    S_FIM_ERRO    = 4'b1110,
    S_FIM_TIMEOUT = 4'b1111
  } estado_t;

  estado_t       estado;
  estado_t       proximo_estado;
  logic          jogada_d;
  logic          pulso_jogada;
  logic [CW-1:0] cnt_timeout;
  logic          fim_contagem;

  assign pulso_jogada = jogada & ~jogada_d;
  assign fim_contagem = (cnt_timeout == CNT_MAX);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= S_INICIAL;
    end else begin
      estado <= proximo_estado;
    end
  end

  // The previous button level runs in every state. A press that is already
  // held when espera begins therefore produces no edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada_d <= 1'b0;
    end else begin
      jogada_d <= jogada;
    end
  end

  // Idle counter for espera. It is held at its terminal value instead of
  // wrapping, because the FSM leaves espera on that same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_timeout <= '0;
    end else if (estado != S_ESPERA) begin
      cnt_timeout <= '0;
    end else if (!fim_contagem) begin
      cnt_timeout <= cnt_timeout + 1'b1;
    end
  end

  // Next-state logic. In espera a move edge takes priority over the timeout.
  always_comb begin
    proximo_estado = S_INICIAL;
    case (estado)
      S_INICIAL:     proximo_estado = iniciar ? S_PREPARACAO : S_INICIAL;
      S_PREPARACAO:  proximo_estado = S_ESPERA;
      S_ESPERA: begin
        if (pulso_jogada) begin
          proximo_estado = S_REGISTRA;
        end else if (fim_contagem) begin
          proximo_estado = S_FIM_TIMEOUT;
        end else begin
          proximo_estado = S_ESPERA;
        end
      end
      S_REGISTRA:    proximo_estado = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!chavesIgualMemoria) begin
          proximo_estado = S_FIM_ERRO;
        end else if (fimC) begin
          proximo_estado = S_FIM_ACERTO;
        end else begin
          proximo_estado = S_PROXIMO;
        end
      end
      S_PROXIMO:     proximo_estado = S_ESPERA;
      S_FIM_ACERTO:  proximo_estado = iniciar ? S_PREPARACAO : S_FIM_ACERTO;
      S_FIM_ERRO:    proximo_estado = iniciar ? S_PREPARACAO : S_FIM_ERRO;
      S_FIM_TIMEOUT: proximo_estado = iniciar ? S_PREPARACAO : S_FIM_TIMEOUT;
      default:       proximo_estado = S_INICIAL;
    endcase
  end

  // Moore outputs are decoded from the state register only.
  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    db_estado = estado;
    case (estado)
      S_PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      S_REGISTRA:    registraR = 1'b1;
      S_PROXIMO:     contaC = 1'b1;
      S_FIM_ACERTO: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      S_FIM_ERRO: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      S_FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// tb_exp4_unidade_controle
// ---------------------------------------------------------------------------
// Bench for the experiment-4 control unit with a short timeout (8 cycles).
// A phase-level model of the game round predicts every output on every
// cycle. Hand-computed literals pin the key points of each scenario: reset,
// a full win, a miss on the third move, a timeout, a held button, a move
// arriving at the terminal count, and an asynchronous reset mid-round.
// ---------------------------------------------------------------------------
module tb_exp4_unidade_controle;

  localparam int T = 8;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic       jogada;
  logic       chavesIgualMemoria;
  logic       fimC;
  logic       zeraC;
  logic       contaC;
  logic       zeraR;
  logic       registraR;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] db_estado;

  int n_compared = 0;
  int n_mismatch = 0;
  int n_registra = 0;
  int n_conta    = 0;

  exp4_unidade_controle #(.TIMEOUT_CICLOS(T)) dut (
    .clock(clock),
    .reset(reset),
    .iniciar(iniciar),
    .jogada(jogada),
    .chavesIgualMemoria(chavesIgualMemoria),
    .fimC(fimC),
    .zeraC(zeraC),
    .contaC(contaC),
    .zeraR(zeraR),
    .registraR(registraR),
    .pronto(pronto),
    .acertou(acertou),
    .errou(errou),
    .timeout(timeout),
    .db_estado(db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Round model: it tracks the phase by name, the number of whole cycles
  // spent waiting for a move, and the last button level.
  typedef enum int {M_IDLE, M_PREP, M_WAIT, M_REG, M_CMP, M_NEXT,
                    M_WIN, M_MISS, M_TOUT} phase_t;

  phase_t m_phase    = M_IDLE;
  int     m_waited   = 0;
  logic   m_prev_jog = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase    = M_IDLE;
      m_waited   = 0;
      m_prev_jog = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: if (iniciar) m_phase = M_PREP;
        M_PREP: begin
          m_phase  = M_WAIT;
          m_waited = 0;
        end
        M_WAIT: begin
          if (jogada && !m_prev_jog) begin
            m_phase = M_REG;
          end else if (m_waited + 1 == T) begin
            m_phase = M_TOUT;
          end else begin
            m_waited = m_waited + 1;
          end
        end
        M_REG: m_phase = M_CMP;
        M_CMP: begin
          if (!chavesIgualMemoria) m_phase = M_MISS;
          else if (fimC)           m_phase = M_WIN;
          else                     m_phase = M_NEXT;
        end
        M_NEXT: begin
          m_phase  = M_WAIT;
          m_waited = 0;
        end
        default: if (iniciar) m_phase = M_PREP;
      endcase
      m_prev_jog = jogada;
    end
  end

  // Packed expectation: {display code, zeraC, contaC, zeraR, registraR,
  // pronto, acertou, errou, timeout}.
  function automatic logic [11:0] expected_of(phase_t p);
    case (p)
      M_PREP:  return {4'b0001, 8'b1010_0000};
      M_WAIT:  return {4'b0010, 8'b0000_0000};
      M_REG:   return {4'b0100, 8'b0001_0000};
      M_CMP:   return {4'b0101, 8'b0000_0000};
      M_NEXT:  return {4'b0110, 8'b0100_0000};
      M_WIN:   return {4'b1010, 8'b0000_1100};
      M_MISS:  return {4'b1110, 8'b0000_1010};
      M_TOUT:  return {4'b1111, 8'b0000_1001};
      default: return {4'b0000, 8'b0000_0000};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual,
                             input logic [3:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives the inputs a little after a rising edge, then advances n edges.
  task automatic applyStimulus(input logic ini, input logic jog, input logic igual,
                               input logic fim, input int n);
    iniciar            = ini;
    jogada             = jog;
    chavesIgualMemoria = igual;
    fimC               = fim;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  // One button press that is released after a cycle. Control returns one
  // cycle after the outcome state is entered.
  task automatic do_move(input logic igual, input logic fim);
    applyStimulus(1'b0, 1'b1, igual, fim, 1);
    applyStimulus(1'b0, 1'b0, igual, fim, 3);
  endtask

  logic [11:0] exp_vec;

  // Cycle-by-cycle comparison on the falling edge.
  always @(negedge clock) begin
    exp_vec = expected_of(m_phase);
    checkOutput("db_estado", db_estado, exp_vec[11:8]);
    checkOutput("zeraC",     {3'b0, zeraC},     {3'b0, exp_vec[7]});
    checkOutput("contaC",    {3'b0, contaC},    {3'b0, exp_vec[6]});
    checkOutput("zeraR",     {3'b0, zeraR},     {3'b0, exp_vec[5]});
    checkOutput("registraR", {3'b0, registraR}, {3'b0, exp_vec[4]});
    checkOutput("pronto",    {3'b0, pronto},    {3'b0, exp_vec[3]});
    checkOutput("acertou",   {3'b0, acertou},   {3'b0, exp_vec[2]});
    checkOutput("errou",     {3'b0, errou},     {3'b0, exp_vec[1]});
    checkOutput("timeout",   {3'b0, timeout},   {3'b0, exp_vec[0]});
    if (registraR === 1'b1) n_registra++;
    if (contaC === 1'b1)    n_conta++;
  end

  int base_reg;
  int base_conta;

  initial begin
    reset              = 1'b1;
    iniciar            = 1'b0;
    jogada             = 1'b0;
    chavesIgualMemoria = 1'b0;
    fimC               = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    checkOutput("reset_db", db_estado, 4'b0000);
    checkOutput("reset_pronto", {3'b0, pronto}, 4'b0000);

    // Full win: 16 hits, with the carry present only on the last compare.
    base_reg   = n_registra;
    base_conta = n_conta;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("prep_db", db_estado, 4'b0001);
    checkOutput("prep_zera", {2'b0, zeraC, zeraR}, 4'b0011);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("espera_db", db_estado, 4'b0010);
    for (int i = 0; i < 15; i++) do_move(1'b1, 1'b0);
    do_move(1'b1, 1'b1);
    checkOutput("win_db", db_estado, 4'b1010);
    checkOutput("win_flags", {2'b0, pronto, acertou}, 4'b0011);
    checkOutput("win_registra_count", 4'(n_registra - base_reg), 4'd16);
    checkOutput("win_conta_count", 4'(n_conta - base_conta), 4'd15);

    // A new round that misses on the third move.
    base_conta = n_conta;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("restart_win_db", db_estado, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    do_move(1'b1, 1'b0);
    do_move(1'b1, 1'b0);
    do_move(1'b0, 1'b0);
    checkOutput("miss_db", db_estado, 4'b1110);
    checkOutput("miss_flags", {2'b0, pronto, errou}, 4'b0011);
    checkOutput("miss_conta_count", 4'(n_conta - base_conta), 4'd2);

    // Restart from the miss state, then play one normal move.
    base_conta = n_conta;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("restart_err_db", db_estado, 4'b0001);
    checkOutput("restart_err_zera", {2'b0, zeraC, zeraR}, 4'b0011);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    do_move(1'b1, 1'b0);
    checkOutput("restart_move_db", db_estado, 4'b0010);
    checkOutput("restart_move_conta", 4'(n_conta - base_conta), 4'd1);

    // Timeout: espera was just entered, so 8 idle cycles are allowed.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7);
    checkOutput("tout_last_wait_db", db_estado, 4'b0010);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("tout_db", db_estado, 4'b1111);
    checkOutput("tout_flag", {3'b0, timeout}, 4'b0001);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("tout_restart_zera", {2'b0, zeraC, zeraR}, 4'b0011);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Button held for 20 cycles: one registration, then an idle timeout.
    base_reg = n_registra;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 20);
    checkOutput("held_registra_count", 4'(n_registra - base_reg), 4'd1);
    checkOutput("held_db", db_estado, 4'b1111);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);

    // A press whose edge arrives on the terminal-count cycle still counts as a move.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("edge_at_terminal_db", db_estado, 4'b0100);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3);
    checkOutput("edge_at_terminal_after", db_estado, 4'b0010);

    // Asynchronous reset while in registra.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkOutput("pre_reset_db", db_estado, 4'b0100);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_db", db_estado, 4'b0000);
    checkOutput("async_reset_registraR", {3'b0, registraR}, 4'b0000);
    @(posedge clock);
    #2;
    reset  = 1'b0;
    jogada = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("post_reset_prep", db_estado, 4'b0001);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("post_reset_espera", db_estado, 4'b0010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
